cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//   Run/halt/single-step sequencer for the tiny_cpu accumulator core. Gates the core
//   with cpu_en and cpu_rst_n, takes 2-bit commands over a valid/ready handshake,
//   stops on a HALT opcode or a PC breakpoint, and counts enabled cycles.
//   Sits between the top-level ui_in decode and tiny_cpu.
// PARAMETERS
//   PC_W     8   width of the core program counter
//   CNT_W    16  width of the run-cycle counter
//   RST_CYC  4   cycles cpu_rst_n is held low on each core reset (>=1)
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   cmd_valid    in   1      command present
//   cmd          in   2      0=RUN 1=HALT 2=STEP 3=CORE_RESET
//   cmd_ready    out  1      command accepted when cmd_valid&cmd_ready
//   pc           in   PC_W   core PC (address of next instruction)
//   insn_done    in   1      core retire pulse, 1 cycle per instruction
//   halt_insn    in   1      retiring instruction is HALT (qualified by insn_done)
//   bp_set       in   1      load bp_addr into breakpoint register, arm it
//   bp_addr      in   PC_W   breakpoint address
//   cpu_en       out  1      core clock-enable
//   cpu_rst_n    out  1      core synchronous reset, active low
//   state_o      out  3      current FSM state encoding
//   halt_cause   out  2      bit0=HALT opcode, bit1=breakpoint; sticky until next RUN/STEP
//   run_cycles   out  CNT_W  count of cycles with cpu_en=1, saturating
// BEHAVIOUR
//   - All outputs registered. Reset values: state=CPURST, cpu_en=0, cpu_rst_n=0,
//     cmd_ready=0, halt_cause=0, run_cycles=0, reset counter=RST_CYC-1.
//   - States: CPURST=0 IDLE=1 RUN=2 DRAIN=3 STEP=4 HALTED=5.
//   - CPURST: cpu_rst_n=0 for exactly RST_CYC cycles, then IDLE; cpu_rst_n=1 from the same edge.
//   - cmd_ready=1 in IDLE, RUN, HALTED; 0 in CPURST, DRAIN, STEP. A command is consumed
//     only on handshake; no buffering.
//   - IDLE/HALTED: RUN -> RUN, STEP -> STEP, HALT -> ignored (accepted, no-op).
//   - RUN/STEP entry clears halt_cause. cpu_en=1 from the cycle after acceptance.
//   - RUN: HALT cmd -> DRAIN. insn_done&halt_insn -> HALTED, cause bit0.
//     Breakpoint (armed, insn_done, pc==bp) -> HALTED, cause bit1; both can be set together.
//     RUN cmd in RUN is a no-op.
//   - DRAIN: cpu_en stays 1 until insn_done, then HALTED (cause 0 unless opcode/bp also hit).
//     HALT cmd in RUN with insn_done in the same cycle -> HALTED directly.
//   - STEP: cpu_en=1 until first insn_done, then HALTED; halt/bp causes recorded likewise.
//   - cpu_en=0 on the edge that enters HALTED; no extra instruction retires.
//   - CORE_RESET accepted in any ready state -> CPURST; clears run_cycles and halt_cause;
//     the breakpoint stays armed.
//   - bp_set is sampled every cycle regardless of state; it takes effect for the next compare.
//   - run_cycles += 1 each cycle cpu_en=1; holds at 2^CNT_W-1.
//   - Async rst_n mid-RUN: immediate return to reset values; breakpoint disarmed.
// CONFIGURATION
//   BREAKPOINT_EN defined: breakpoint register, compare and halt_cause[1] present.
//   Not defined: bp_set/bp_addr ignored, halt_cause[1] tied 0, no compare logic.
// STRUCTURE
//   cpu_ctrl_pkg: state encodings, cmd encodings (CMD_RUN.. CMD_CORE_RESET),
//     halt_cause bit indices.
//   One sub-module: sat_counter (CNT_W, enable, sync clear, saturate) for run_cycles.
//   The FSM, reset timer and breakpoint compare stay in this module.
// TESTING
//   1 Release rst_n; hold cmd_valid=0 -> cpu_rst_n low exactly 4 cycles, state IDLE,
//     cpu_en=0, run_cycles=0.
//   2 RUN, then insn_done every cycle; HALT on cycle 10 with no insn_done -> DRAIN, cpu_en
//     held until the next insn_done, then HALTED; run_cycles equals enabled-cycle count.
//   3 From IDLE, STEP with insn_done 3 cycles later -> cpu_en high exactly 3 cycles,
//     then HALTED, cmd_ready=1.
//   4 RUN; insn_done&halt_insn at pc=0x12 -> HALTED, halt_cause=01; the next RUN clears it.
//   5 (BREAKPOINT_EN) bp_set bp_addr=0x05; RUN; retire at pc=0x05 with halt_insn=1 ->
//     HALTED, halt_cause=11.
//   6 CORE_RESET in RUN with run_cycles=0xFFFF (CNT_W=16, forced saturate) -> CPURST,
//     counter 0; assert rst_n low mid-RUN -> all outputs at reset values.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the tiny_cpu run/halt/step sequencer.
package cpu_ctrl_pkg;
  localparam logic [2:0] ST_CPURST = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_STEP   = 3'd4;
  localparam logic [2:0] ST_HALTED = 3'd5;

  typedef enum logic [1:0] {
    CMD_RUN        = 2'd0,
    CMD_HALT       = 2'd1,
    CMD_STEP       = 2'd2,
    CMD_CORE_RESET = 2'd3
  } cmd_e;

  localparam int HC_OPCODE = 0;
  localparam int HC_BP     = 1;
endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command valid/ready channel into the run controller.
interface cpu_run_ctrl_if;
  import cpu_ctrl_pkg::*;
  logic cmd_valid;
  cmd_e cmd;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (en_i && cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for tiny_cpu: core reset timer, command FSM,
// optional PC breakpoint (define BREAKPOINT_EN) and enabled-cycle counter.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_run_ctrl_if.slave    cmd_bus,
  input  logic [PC_W-1:0]  pc,
  input  logic             insn_done,
  input  logic             halt_insn,
  input  logic             bp_set,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic [2:0]       state_o,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] run_cycles
);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [1:0]      cause_q, cause_d;
  logic            cpu_en_q, cpu_rst_n_q, ready_q;
  logic            accept, clr_cnt, hit_op, hit_bp;

  assign accept = cmd_bus.cmd_valid & ready_q;
  assign hit_op = insn_done & halt_insn;

`ifdef BREAKPOINT_EN
  logic [PC_W-1:0] bp_q;
  logic            bp_arm_q;

  // Compare uses the registered address, so a load lands on the next compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_q     <= '0;
      bp_arm_q <= 1'b0;
    end else if (bp_set) begin
      bp_q     <= bp_addr;
      bp_arm_q <= 1'b1;
    end
  end

  assign hit_bp = bp_arm_q & insn_done & (pc == bp_q);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_set, bp_addr, pc};
  assign hit_bp    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cause_d   = cause_q;
    clr_cnt   = 1'b0;
    if (accept && cmd_bus.cmd == CMD_CORE_RESET) begin
      state_d   = ST_CPURST;
      rst_cnt_d = RC_INIT;
      cause_d   = 2'b00;
      clr_cnt   = 1'b1;
    end else begin
      case (state_q)
        ST_CPURST: begin
          if (rst_cnt_q == '0) state_d = ST_IDLE;
          else                 rst_cnt_d = rst_cnt_q - 1'b1;
        end
        ST_IDLE, ST_HALTED: begin
          if (accept && cmd_bus.cmd == CMD_RUN) begin
            state_d = ST_RUN;
            cause_d = 2'b00;
          end else if (accept && cmd_bus.cmd == CMD_STEP) begin
            state_d = ST_STEP;
            cause_d = 2'b00;
          end
        end
        ST_RUN: begin
          if (hit_op || hit_bp) begin
            state_d = ST_HALTED;
            cause_d = cause_q | {hit_bp, hit_op};
          end else if (accept && cmd_bus.cmd == CMD_HALT) begin
            state_d = insn_done ? ST_HALTED : ST_DRAIN;
          end
        end
        ST_DRAIN, ST_STEP: begin
          if (insn_done) begin
            state_d = ST_HALTED;
            cause_d = cause_q | {hit_bp, hit_op};
          end
        end
        default: begin
          state_d   = ST_CPURST;
          rst_cnt_d = RC_INIT;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CPURST;
      rst_cnt_q   <= RC_INIT;
      cause_q     <= 2'b00;
      cpu_en_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cause_q     <= cause_d;
      cpu_en_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_STEP);
      cpu_rst_n_q <= (state_d != ST_CPURST);
      ready_q     <= (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (cpu_en_q),
    .clr_i (clr_cnt),
    .cnt_o (run_cycles)
  );

  assign cmd_bus.cmd_ready = ready_q;
  assign cpu_en            = cpu_en_q;
  assign cpu_rst_n         = cpu_rst_n_q;
  assign state_o           = state_q;
  assign halt_cause        = cause_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a queue-based expectation scoreboard.
module tb_cpu_run_ctrl;
  import cpu_ctrl_pkg::*;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             insn_done = 1'b0, halt_insn = 1'b0, bp_set = 1'b0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             cpu_en, cpu_rst_n;
  logic [2:0]       state_o;
  logic [1:0]       halt_cause;
  logic [CNT_W-1:0] run_cycles;

  cpu_run_ctrl_if cif();

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RST_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_bus    (cif.slave),
    .pc         (pc),
    .insn_done  (insn_done),
    .halt_insn  (halt_insn),
    .bp_set     (bp_set),
    .bp_addr    (bp_addr),
    .cpu_en     (cpu_en),
    .cpu_rst_n  (cpu_rst_n),
    .state_o    (state_o),
    .halt_cause (halt_cause),
    .run_cycles (run_cycles)
  );

  int          tests = 0;
  int          failed = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty got %0h want nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s got %0h want %0h", t, obs, e);
      end
    end
  endtask

  task automatic exp_ctl(input string t, input logic [2:0] st, input logic en,
                         input logic rn, input logic rdy, input logic [1:0] hc);
    push({t, ".state"}, 32'(st));
    push({t, ".cpu_en"}, 32'(en));
    push({t, ".cpu_rst_n"}, 32'(rn));
    push({t, ".cmd_ready"}, 32'(rdy));
    push({t, ".halt_cause"}, 32'(hc));
  endtask

  task automatic obs_ctl();
    pop(32'(state_o));
    pop(32'(cpu_en));
    pop(32'(cpu_rst_n));
    pop(32'(cif.cmd_ready));
    pop(32'(halt_cause));
  endtask

  task automatic send(input cmd_e c);
    cif.cmd_valid = 1'b1;
    cif.cmd = c;
    tick();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    int lowcnt;
    cif.cmd_valid = 1'b0;
    cif.cmd = CMD_RUN;

    // Reset values
    exp_ctl("rst", ST_CPURST, 1'b0, 1'b0, 1'b0, 2'b00);
    push("rst.run_cycles", 32'h0);
    repeat (3) tick();
    obs_ctl();
    pop(32'(run_cycles));

    // 1: core reset held exactly four cycles
    rst_n = 1'b1;
    lowcnt = 0;
    while (!cpu_rst_n && lowcnt < 20) begin
      lowcnt++;
      tick();
    end
    push("t1.low_cycles", 32'd4);
    pop(32'(lowcnt));
    exp_ctl("t1", ST_IDLE, 1'b0, 1'b1, 1'b1, 2'b00);
    push("t1.run_cycles", 32'h0);
    obs_ctl();
    pop(32'(run_cycles));

    // 2: RUN, retire every cycle, HALT on cycle 10 without retire -> DRAIN
    exp_ctl("t2.run", ST_RUN, 1'b1, 1'b1, 1'b1, 2'b00);
    send(CMD_RUN);
    obs_ctl();
    insn_done = 1'b1;
    repeat (9) tick();
    insn_done = 1'b0;
    exp_ctl("t2.drain", ST_DRAIN, 1'b1, 1'b1, 1'b0, 2'b00);
    send(CMD_HALT);
    obs_ctl();
    exp_ctl("t2.drain_hold", ST_DRAIN, 1'b1, 1'b1, 1'b0, 2'b00);
    tick();
    obs_ctl();
    insn_done = 1'b1;
    exp_ctl("t2.halted", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b00);
    tick();
    insn_done = 1'b0;
    obs_ctl();
    // 9 run + 1 halt-request + 1 drain wait + 1 retiring cycle
    push("t2.run_cycles", 32'd12);
    tick();
    pop(32'(run_cycles));

    // 3: CORE_RESET back to IDLE, then STEP retiring on the third enabled cycle
    exp_ctl("t3.cpurst", ST_CPURST, 1'b0, 1'b0, 1'b0, 2'b00);
    push("t3.clr_cycles", 32'h0);
    send(CMD_CORE_RESET);
    obs_ctl();
    pop(32'(run_cycles));
    repeat (4) tick();
    exp_ctl("t3.idle", ST_IDLE, 1'b0, 1'b1, 1'b1, 2'b00);
    obs_ctl();
    exp_ctl("t3.step", ST_STEP, 1'b1, 1'b1, 1'b0, 2'b00);
    send(CMD_STEP);
    obs_ctl();
    repeat (2) tick();
    insn_done = 1'b1;
    exp_ctl("t3.halted", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b00);
    push("t3.run_cycles", 32'd3);
    tick();
    insn_done = 1'b0;
    obs_ctl();
    pop(32'(run_cycles));

    // 4: HALT opcode at pc 0x12, sticky cause, HALT ignored while halted, RUN clears
    send(CMD_RUN);
    repeat (2) tick();
    pc = 8'h12;
    insn_done = 1'b1;
    halt_insn = 1'b1;
    exp_ctl("t4.op_halt", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b01);
    tick();
    insn_done = 1'b0;
    halt_insn = 1'b0;
    pc = 8'h00;
    obs_ctl();
    exp_ctl("t4.halt_noop", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b01);
    send(CMD_HALT);
    obs_ctl();
    exp_ctl("t4.rerun", ST_RUN, 1'b1, 1'b1, 1'b1, 2'b00);
    send(CMD_RUN);
    obs_ctl();
    // HALT with a retire in the same cycle skips DRAIN
    insn_done = 1'b1;
    exp_ctl("t4.direct", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b00);
    send(CMD_HALT);
    insn_done = 1'b0;
    obs_ctl();

    // 5: breakpoint at 0x05
    bp_set = 1'b1;
    bp_addr = 8'h05;
    tick();
    bp_set = 1'b0;
    send(CMD_RUN);
    pc = 8'h05;
    insn_done = 1'b1;
`ifdef BREAKPOINT_EN
    halt_insn = 1'b1;
    exp_ctl("t5.bp_op", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b11);
    tick();
`else
    exp_ctl("t5.no_bp", ST_RUN, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    obs_ctl();
    exp_ctl("t5.stop", ST_HALTED, 1'b0, 1'b1, 1'b1, 2'b00);
    send(CMD_HALT);
`endif
    insn_done = 1'b0;
    halt_insn = 1'b0;
    pc = 8'h00;
    obs_ctl();

    // 6: saturate run_cycles, CORE_RESET clears it, async reset mid-RUN
    send(CMD_CORE_RESET);
    repeat (4) tick();
    send(CMD_RUN);
    repeat (65540) tick();
    push("t6.sat", 32'h0000_FFFF);
    pop(32'(run_cycles));
    push("t6.sat_hold", 32'h0000_FFFF);
    tick();
    pop(32'(run_cycles));
    exp_ctl("t6.core_rst", ST_CPURST, 1'b0, 1'b0, 1'b0, 2'b00);
    push("t6.clr", 32'h0);
    send(CMD_CORE_RESET);
    obs_ctl();
    pop(32'(run_cycles));
    repeat (4) tick();
    send(CMD_RUN);
    repeat (3) tick();
    rst_n = 1'b0;
    exp_ctl("t6.async", ST_CPURST, 1'b0, 1'b0, 1'b0, 2'b00);
    push("t6.async_cycles", 32'h0);
    #1;
    obs_ctl();
    pop(32'(run_cycles));
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    send(CMD_RUN);
    // Breakpoint must be disarmed by rst_n, so a retire at 0x05 keeps running
    pc = 8'h05;
    insn_done = 1'b1;
    exp_ctl("t6.bp_disarmed", ST_RUN, 1'b1, 1'b1, 1'b1, 2'b00);
    tick();
    insn_done = 1'b0;
    obs_ctl();

    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
